// File: rtl/learning_engine.sv
// learning_engine: walks a song in note memory, plays each note, judges the answer, keeps a score.
// Define LEARN_RETRY_EN to replay a missed note up to MAX_TRIES times before moving on.
module learning_engine #(
    parameter int NOTE_W    = 4,
    parameter int DUR_W     = 26,
    parameter int ADDR_W    = 5,
    parameter int SONG_LEN  = 32,
    parameter int SCORE_W   = 6,
    parameter int TIMEOUT   = 100000000,
    parameter int MAX_TRIES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NOTE_W-1:0]  user_input,
    input  logic               confirm_button,
    input  logic [NOTE_W-1:0]  note_value,
    input  logic [DUR_W-1:0]   duration_value,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [NOTE_W-1:0]  key,
    output logic               key_on,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done,
    output logic               last_correct
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int WLK_W = $clog2(SONG_LEN + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [WLK_W-1:0] WLK_LAST = WLK_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY,
        S_WAIT, S_JUDGE, S_ADV, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NOTE_W-1:0]  key_q, key_d;
    logic [DUR_W-1:0]   dlen_q, dlen_d;
    logic [DUR_W-1:0]   dcnt_q, dcnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tmo_hit_q, tmo_hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               last_q, last_d;
    logic [WLK_W-1:0]   walked_q, walked_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [2:0]         sync_q;

    logic strobe;
    logic correct;
    logic retry;
    logic [DUR_W-1:0] dur_clamped;

    assign strobe      = sync_q[1] & ~sync_q[2];
    assign correct     = ~tmo_hit_q & (user_input == key_q);
    assign dur_clamped = (duration_value == '0) ? DUR_W'(1) : duration_value;

`ifdef LEARN_RETRY_EN
    assign retry = ~correct & ((int'(tries_q) + 1) < MAX_TRIES);
`else
    assign retry = 1'b0;
`endif

    // Two-flop synchroniser plus one delay flop for rising-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], confirm_button};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = (note_value == '0) ? S_DONE : S_PLAY;
            S_PLAY:  if (dcnt_q == DUR_W'(1)) state_d = S_WAIT;
            S_WAIT:  if (strobe || tmo_q == '0) state_d = S_JUDGE;
            S_JUDGE: state_d = retry ? S_PLAY : S_ADV;
            S_ADV:   state_d = (walked_q == WLK_LAST) ? S_DONE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy   = (state_q != S_IDLE) && (state_q != S_DONE);
        done   = (state_q == S_DONE);
        key_on = (state_q == S_PLAY);
    end

    // Datapath next-state: address, note latch, counters and score
    always_comb begin
        addr_d    = addr_q;
        key_d     = key_q;
        dlen_d    = dlen_q;
        dcnt_d    = dcnt_q;
        tmo_d     = tmo_q;
        tmo_hit_d = tmo_hit_q;
        score_d   = score_q;
        last_d    = last_q;
        walked_d  = walked_q;
        tries_d   = tries_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d   = '0;
                    score_d  = '0;
                    walked_d = '0;
                end
            end
            S_LOAD: begin
                if (note_value != '0) key_d = note_value;
                dlen_d  = dur_clamped;
                dcnt_d  = dur_clamped;
                tries_d = '0;
            end
            S_PLAY: begin
                dcnt_d    = dcnt_q - DUR_W'(1);
                tmo_d     = TMO_LOAD;
                tmo_hit_d = 1'b0;
            end
            S_WAIT: begin
                tmo_d     = tmo_q - TMO_W'(1);
                tmo_hit_d = ~strobe & (tmo_q == '0);
            end
            S_JUDGE: begin
                last_d  = correct;
                tries_d = tries_q + TRY_W'(1);
                dcnt_d  = dlen_q;
                if (correct && score_q != {SCORE_W{1'b1}})
                    score_d = score_q + SCORE_W'(1);
            end
            S_ADV: begin
                addr_d   = addr_q + ADDR_W'(1);
                walked_d = walked_q + WLK_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            key_q     <= '0;
            dlen_q    <= '0;
            dcnt_q    <= '0;
            tmo_q     <= '0;
            tmo_hit_q <= 1'b0;
            score_q   <= '0;
            last_q    <= 1'b0;
            walked_q  <= '0;
            tries_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            key_q     <= key_d;
            dlen_q    <= dlen_d;
            dcnt_q    <= dcnt_d;
            tmo_q     <= tmo_d;
            tmo_hit_q <= tmo_hit_d;
            score_q   <= score_d;
            last_q    <= last_d;
            walked_q  <= walked_d;
            tries_q   <= tries_d;
        end
    end

    assign mem_addr     = addr_q;
    assign key          = key_q;
    assign score        = score_q;
    assign last_correct = last_q;

endmodule

// File: tb/tb_learning_engine.sv
// tb_learning_engine: directed and random lessons against a per-note reference model.
// The model follows LEARN_RETRY_EN the same way the design build does.
module tb_learning_engine;

    localparam int NW = 4;
    localparam int DW = 4;
    localparam int AW = 3;
    localparam int SL = 8;
    localparam int SW = 2;
    localparam int TO = 10;
    localparam int MT = 3;
    localparam int MAXSC = (1 << SW) - 1;
`ifdef LEARN_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          confirm_button = 1'b0;
    logic [NW-1:0] user_input = '0;
    logic [NW-1:0] note_value;
    logic [DW-1:0] duration_value;
    logic [AW-1:0] mem_addr;
    logic [NW-1:0] key;
    logic          key_on;
    logic [SW-1:0] score;
    logic          busy;
    logic          done;
    logic          last_correct;

    learning_engine #(
        .NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW), .SONG_LEN(SL),
        .SCORE_W(SW), .TIMEOUT(TO), .MAX_TRIES(MT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .user_input(user_input), .confirm_button(confirm_button),
        .note_value(note_value), .duration_value(duration_value),
        .mem_addr(mem_addr), .key(key), .key_on(key_on),
        .score(score), .busy(busy), .done(done),
        .last_correct(last_correct)
    );

    always #5 clk = ~clk;

    int song[8];
    int durs[8];

    // Synchronous-read song memory: data follows the address by one cycle
    always @(posedge clk) begin
        note_value     <= NW'(song[mem_addr]);
        duration_value <= DW'(durs[mem_addr]);
    end

    int tests = 0;
    int fails = 0;

    int plan[$];
    int exp_key[$];
    int exp_len[$];
    int exp_gap[$];
    int exp_score;
    int exp_addr;
    int exp_last = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the song note by note, consuming one planned attempt per play
    task automatic model();
        int q[$];
        int a, w, tries, sc;
        bit ok, adv;
        q = plan;
        exp_key.delete();
        exp_len.delete();
        exp_gap.delete();
        sc = 0;
        w = 0;
        while (w < SL && song[w] != 0) begin
            tries = 0;
            adv = 0;
            while (!adv) begin
                a = (q.size() > 0) ? q.pop_front() : -1;
                exp_key.push_back(song[w]);
                exp_len.push_back(durs[w] == 0 ? 1 : durs[w]);
                ok = (a == song[w]);
                exp_last = ok;
                if (ok && sc < MAXSC) sc++;
                tries++;
                adv = ok || !RETRY || tries >= MT;
                if (a >= 0)
                    exp_gap.push_back(0);
                else if (!adv)
                    exp_gap.push_back(TO + 1);
                else if (w + 1 < SL && song[w + 1] != 0)
                    exp_gap.push_back(TO + 4);
                else
                    exp_gap.push_back(0);
            end
            w++;
        end
        exp_score = sc;
        exp_addr = w % (1 << AW);
    endtask

    // Drive one lesson from start to DONE, answering per the plan
    // Attempt codes: >=0 answer, -1 let it time out, -2 time out after a stray confirm/start in PLAY
    task automatic run_lesson(input string tag);
        int q[$];
        int cyc, hi, fall_cyc, first_on, gap_exp, off_cyc, a;
        bit prev_on;
        model();
        q = plan;
        cyc = 0; hi = 0; fall_cyc = -1; first_on = -1;
        gap_exp = 0; off_cyc = -1; prev_on = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 3000) begin
            cyc++;
            if (cyc == off_cyc) begin
                confirm_button = 1'b0;
                start = 1'b0;
            end
            if (key_on && !prev_on) begin
                if (first_on < 0) first_on = cyc;
                if (gap_exp > 0) check({tag, ".timeout_gap"}, cyc - fall_cyc, gap_exp);
                gap_exp = 0;
                check({tag, ".key"}, int'(key), exp_key.size() > 0 ? exp_key.pop_front() : -1);
                if (q.size() > 0 && q[0] == -2) begin
                    user_input = key;
                    confirm_button = 1'b1;
                    start = 1'b1;
                    off_cyc = cyc + 1;
                end
                hi = 0;
            end
            if (key_on) hi++;
            if (!key_on && prev_on) begin
                check({tag, ".play_len"}, hi, exp_len.size() > 0 ? exp_len.pop_front() : -1);
                gap_exp = exp_gap.size() > 0 ? exp_gap.pop_front() : 0;
                fall_cyc = cyc;
                a = (q.size() > 0) ? q.pop_front() : -1;
                if (a >= 0) begin
                    user_input = NW'(a);
                    confirm_button = 1'b1;
                    off_cyc = cyc + 2;
                end
            end
            prev_on = key_on;
            @(posedge clk); #1;
        end
        confirm_button = 1'b0;
        start = 1'b0;
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".key_on"}, int'(key_on), 0);
        check({tag, ".score"}, int'(score), exp_score);
        check({tag, ".last_correct"}, int'(last_correct), exp_last);
        check({tag, ".mem_addr"}, int'(mem_addr), exp_addr);
        check({tag, ".plays_missing"}, exp_key.size(), 0);
        if (song[0] != 0) check({tag, ".latency"}, first_on, 3);
    endtask

    task automatic wait_key_on(input string tag, input bit lvl);
        int n;
        n = 0;
        while (key_on !== lvl && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, int'(key_on), int'(lvl));
    endtask

    initial begin
        song = '{3, 5, 0, 0, 0, 0, 0, 0};
        durs = '{4, 4, 4, 4, 4, 4, 4, 4};
        #1 rst = 1'b1;
        #3;
        check("reset.mem_addr", int'(mem_addr), 0);
        check("reset.key", int'(key), 0);
        check("reset.key_on", int'(key_on), 0);
        check("reset.score", int'(score), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.last_correct", int'(last_correct), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        plan = {3, 5};
        run_lesson("two_notes");

        song = '{7, 0, 0, 0, 0, 0, 0, 0};
        plan = {2};
        run_lesson("wrong_answer");

        song = '{4, 6, 0, 0, 0, 0, 0, 0};
        durs = '{9, 3, 4, 4, 4, 4, 4, 4};
        plan = {-2, 6};
        run_lesson("timeout_stray");

        song = '{7, 2, 0, 0, 0, 0, 0, 0};
        durs = '{3, 2, 4, 4, 4, 4, 4, 4};
        plan = {1, 1, 7, 2};
        run_lesson("retry");

        song = '{1, 2, 3, 4, 5, 0, 0, 0};
        durs = '{1, 0, 2, 1, 3, 1, 1, 1};
        plan = {1, 2, 3, 4, 5};
        run_lesson("saturate");

        song = '{1, 2, 3, 4, 5, 6, 7, 8};
        durs = '{2, 2, 2, 2, 2, 2, 2, 2};
        plan = {1, 2, 3, 4, 5, 6, 7, 8};
        run_lesson("song_len");

        // Reset during the second note's PLAY, after one correct answer
        song = '{3, 5, 0, 0, 0, 0, 0, 0};
        durs = '{4, 4, 4, 4, 4, 4, 4, 4};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_key_on("rst_mid.play1", 1'b1);
        wait_key_on("rst_mid.wait1", 1'b0);
        user_input = 4'd3;
        confirm_button = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        confirm_button = 1'b0;
        wait_key_on("rst_mid.play2", 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.key_on", int'(key_on), 0);
        check("rst_mid.mem_addr", int'(mem_addr), 0);
        check("rst_mid.key", int'(key), 0);
        check("rst_mid.score", int'(score), 0);
        check("rst_mid.busy", int'(busy), 0);
        check("rst_mid.done", int'(done), 0);
        check("rst_mid.last_correct", int'(last_correct), 0);
        exp_last = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        plan = {3, 1};
        run_lesson("after_reset");

        for (int l = 0; l < 6; l++) begin
            int zp, r;
            zp = $urandom_range(0, 9);
            for (int i = 0; i < 8; i++) begin
                song[i] = (i == zp) ? 0 : int'($urandom_range(1, 3));
                durs[i] = $urandom_range(0, 5);
            end
            plan.delete();
            for (int k = 0; k < 24; k++) begin
                r = $urandom_range(0, 3);
                plan.push_back(r == 0 ? -1 : r);
            end
            run_lesson($sformatf("rand%0d", l));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
